serial_adder: RTL and testbench
===============================

# serial_adder

Bit-serial ripple adder built around one full-adder cell and a carry flip-flop. It adds two WIDTH-bit operands LSB-first, one bit per clock. It sits directly downstream of the full-adder cell: it consumes the cell's sum/carry outputs every cycle and feeds the registered carry back as the next cell's carry-in. It trades WIDTH cycles of latency for a single adder cell and a start/busy/done handshake.

## Interface
- WIDTH, 8, operand and result width in bits; legal range 1..32
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request a new addition; sampled on the rising edge of clk
- a  input  WIDTH  operand A; captured only on the edge that accepts start
- b  input  WIDTH  operand B; captured only on the edge that accepts start
- cin  input  1  carry-in; captured only on the edge that accepts start
- busy  output  1  high while bits are being processed
- done  output  1  one-cycle pulse; sum and cout are valid and updated
- sum  output  WIDTH  registered result; holds its value until the next completion
- cout  output  1  registered carry-out of the MSB; holds its value until the next completion

## Operation
- Clock and reset: one clock, `clk`. Reset `rst` is asynchronous and active-high.
- State machine has three states: IDLE, RUN, DONE.
- IDLE:
  - start=1 → load shift registers a_sr←a, b_sr←b; carry←cin; bit counter←0; clear the internal partial-sum register; go to RUN.
  - start=0 → stay in IDLE.
- RUN, each cycle:
  - Full-adder cell computes s = a_sr[0]^b_sr[0]^carry and c = majority(a_sr[0], b_sr[0], carry).
  - partial-sum ← {s, partial-sum[WIDTH-1:1]}.
  - carry ← c.
  - a_sr and b_sr shift right by 1, zero-filled.
  - Counter increments.
- RUN exit: on the cycle the counter reaches WIDTH-1:
  - sum ← final partial-sum, including this cycle's bit.
  - cout ← c.
  - Go to DONE.
- DONE:
  - done=1 for exactly this one cycle.
  - start=1 here is accepted exactly as in IDLE: load, go to RUN.
  - start=0 → go to IDLE.
- start in RUN is ignored; operands are not resampled and the current operation is unaffected.
- Arithmetic: {cout, sum} = a + b + cin, computed modulo 2^(WIDTH+1). No overflow flag.
- WIDTH=1 degenerates to a registered full adder: RUN lasts exactly one cycle.

## Timing
- Reset values: state=IDLE, busy=0, done=0, sum=0, cout=0, carry=0, counter=0, shift registers=0.
- Reset asserted mid-operation aborts the addition immediately. No done pulse follows. sum and cout go to 0.
- busy = (state==RUN). It is registered and does not depend combinationally on start.
- done = (state==DONE). It is registered.
- Latency, with start accepted at edge E0:
  - busy is high for cycles E0..E(WIDTH-1) inclusive, i.e. exactly WIDTH cycles.
  - sum and cout update at edge E(WIDTH).
  - done is high from E(WIDTH) to E(WIDTH+1).
- Throughput: back-to-back operations by holding start high give one result every WIDTH+1 cycles.
- sum and cout never change except at a completion edge or on reset. The partial-sum register is internal only.

## Test plan
- WIDTH=1, all 8 combinations of a, b, cin, one per operation → {cout, sum} equals the full-adder truth table. Example: 1+1+1 → sum=1, cout=1. done pulses 2 cycles after each start.
- WIDTH=8, a=0xFF, b=0x01, cin=0 → sum=0x00, cout=1. busy is high for exactly 8 cycles. done is high for 1 cycle, at cycle 9 after the start edge.
- WIDTH=8, a=0xFF, b=0xFF, cin=1 → sum=0xFF, cout=1. Next: a=0x5A, b=0xA5, cin=0 → sum=0xFF, cout=0.
- WIDTH=8, a=0x3C, b=0x0F, start held high continuously → results of 0x4B arrive every 9 cycles. Changing a to 0x01 while busy has no effect on the current result.
- WIDTH=8, assert rst asynchronously between clock edges during the 4th RUN cycle → busy, done, sum and cout are 0 immediately. A later start with a=0x10, b=0x20 → sum=0x30, cout=0.
- Before any start, sum=0, cout=0, done=0. Previous result 0x30 holds unchanged throughout a following run until its completion edge.

Source files
------------

// File: rtl/serial_adder.sv
// ---------------------------------------------------------------------------
// serial_adder
//
// Bit-serial ripple adder. A single full-adder cell processes one bit per
// clock, LSB first. The carry between bits is held in a flip-flop and fed
// back to the cell on the next cycle. The result {cout, sum} = a + b + cin
// is ready WIDTH cycles after start is accepted.
//
// State table
//   state   | meaning
//   IDLE    | waiting for start
//   RUN     | one operand bit pair added per cycle, WIDTH cycles in total
//   DONE    | one-cycle result pulse; start here begins the next add at once
//
// Ports
//   clk_i    rising-edge clock
//   rst_i    asynchronous, active-high reset
//   start_i  request a new addition (sampled in IDLE and DONE only)
//   a_i      operand A, captured when start is accepted
//   b_i      operand B, captured when start is accepted
//   cin_i    carry-in, captured when start is accepted
//   busy_o   high while bits are being processed
//   done_o   one-cycle pulse, sum_o/cout_o have just been updated
//   sum_o    registered result, held until the next completion
//   cout_o   registered carry-out of the MSB, held until the next completion
// ---------------------------------------------------------------------------
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o
);

    // A 1-bit counter is still needed for WIDTH=1; it just never leaves 0
    // before the exit compare fires.
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic             carry_q, carry_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] ps_q, ps_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;

    logic             fa_s;
    logic             fa_c;
    logic [WIDTH-1:0] ps_shift;

    // Full-adder cell on the current LSBs and the stored carry.
    assign fa_s = a_sr_q[0] ^ b_sr_q[0] ^ carry_q;
    assign fa_c = (a_sr_q[0] & b_sr_q[0]) |
                  (a_sr_q[0] & carry_q)   |
                  (b_sr_q[0] & carry_q);

    // New sum bit enters at the MSB end; after WIDTH shifts the first bit
    // computed has reached bit 0. Written without a part-select so that
    // WIDTH=1 elaborates cleanly.
    assign ps_shift = (ps_q >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            a_sr_q  <= '0;
            b_sr_q  <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            ps_q    <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sr_q  <= a_sr_d;
            b_sr_q  <= b_sr_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            ps_q    <= ps_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_sr_d  = a_sr_q;
        b_sr_d  = b_sr_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        ps_d    = ps_q;
        sum_d   = sum_q;
        cout_d  = cout_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_i) begin
                    a_sr_d  = a_i;
                    b_sr_d  = b_i;
                    carry_d = cin_i;
                    cnt_d   = '0;
                    ps_d    = '0;
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_RUN: begin
                ps_d    = ps_shift;
                carry_d = fa_c;
                a_sr_d  = a_sr_q >> 1;
                b_sr_d  = b_sr_q >> 1;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    sum_d   = ps_shift;
                    cout_d  = fa_c;
                    state_d = ST_DONE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign busy_o = (state_q == ST_RUN);
    assign done_o = (state_q == ST_DONE);
    assign sum_o  = sum_q;
    assign cout_o = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
module tb_serial_adder;

    localparam int W = 8;

    logic         clk;
    logic         rst;

    logic         start8;
    logic [W-1:0] a8, b8;
    logic         cin8;
    logic         busy8, done8;
    logic [W-1:0] sum8;
    logic         cout8;

    logic         start1;
    logic [0:0]   a1, b1;
    logic         cin1;
    logic         busy1, done1;
    logic [0:0]   sum1;
    logic         cout1;

    int total;
    int bad;

    serial_adder #(.WIDTH(W)) dut8 (
        .clk_i   (clk),
        .rst_i   (rst),
        .start_i (start8),
        .a_i     (a8),
        .b_i     (b8),
        .cin_i   (cin8),
        .busy_o  (busy8),
        .done_o  (done8),
        .sum_o   (sum8),
        .cout_o  (cout8)
    );

    serial_adder #(.WIDTH(1)) dut1 (
        .clk_i   (clk),
        .rst_i   (rst),
        .start_i (start1),
        .a_i     (a1),
        .b_i     (b1),
        .cin_i   (cin1),
        .busy_o  (busy1),
        .done_o  (done1),
        .sum_o   (sum1),
        .cout_o  (cout1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain arithmetic, {cout, sum} = a + b + cin.
    function automatic logic [W:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic c);
        return {1'b0, a} + {1'b0, b} + (W+1)'(c);
    endfunction

    // One WIDTH=8 operation with start pulsed for a single cycle. Checks the
    // result, busy duration, done position/width, and that the previous
    // result holds until the completion edge.
    task automatic run8(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                        input string tag);
        logic [W:0] exp;
        logic [W:0] prev;
        logic [W:0] res;
        int         busy_n;
        int         done_n;
        int         done_at;
        logic       held;
        exp  = ref_add(a, b, c);
        prev = {cout8, sum8};
        a8 = a; b8 = b; cin8 = c; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        a8 = ~a; b8 = ~b; cin8 = ~c;
        busy_n = 0; done_n = 0; done_at = -1; held = 1'b1; res = '0;
        for (int cyc = 0; cyc <= W + 2; cyc++) begin
            if (cyc > 0) tick();
            if (busy8) busy_n++;
            if (done8) begin
                done_n++;
                if (done_at < 0) begin
                    done_at = cyc;
                    res = {cout8, sum8};
                end
            end
            if (cyc < W && {cout8, sum8} !== prev) held = 1'b0;
        end
        chk({tag, "_result"}, 64'(res), 64'(exp));
        chk({tag, "_busy_cycles"}, 64'(busy_n), 64'(W));
        chk({tag, "_done_count"}, 64'(done_n), 64'd1);
        chk({tag, "_done_at"}, 64'(done_at), 64'(W));
        chk({tag, "_prev_held"}, 64'(held), 64'd1);
        chk({tag, "_result_hold"}, 64'({cout8, sum8}), 64'(exp));
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        logic         rc;
        int           k;
        logic         seen;
        total = 0;
        bad   = 0;
        rst = 1'b1;
        start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
        start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk("rst_busy", 64'(busy8), 64'd0);
        chk("rst_done", 64'(done8), 64'd0);
        chk("rst_sum", 64'(sum8), 64'd0);
        chk("rst_cout", 64'(cout8), 64'd0);
        chk("rst1_result", 64'({cout1, sum1, busy1, done1}), 64'd0);
        repeat (2) tick();
        chk("idle_no_start", 64'({busy8, done8, cout8, sum8}), 64'd0);

        // WIDTH=1: full-adder truth table, one operation per combination.
        for (int i = 0; i < 8; i++) begin
            logic [2:0] v;
            v = 3'(i);
            a1 = v[2]; b1 = v[1]; cin1 = v[0]; start1 = 1'b1;
            tick();
            start1 = 1'b0;
            chk($sformatf("w1_busy_%0d", i), 64'({busy1, done1}), 64'b10);
            tick();
            chk($sformatf("w1_done_%0d", i), 64'({busy1, done1}), 64'b01);
            chk($sformatf("w1_sum_%0d", i), 64'({cout1, sum1}),
                64'(2'(v[2]) + 2'(v[1]) + 2'(v[0])));
            tick();
            chk($sformatf("w1_idle_%0d", i), 64'(done1), 64'd0);
        end

        run8(8'hFF, 8'h01, 1'b0, "ff_01");
        run8(8'hFF, 8'hFF, 1'b1, "ff_ff_c");
        run8(8'h5A, 8'hA5, 1'b0, "5a_a5");

        // Back-to-back with start held high; operand A disturbed mid-run.
        a8 = 8'h3C; b8 = 8'h0F; cin8 = 1'b0; start8 = 1'b1;
        tick();
        k = 0;
        for (int cyc = 0; cyc <= 3 * (W + 1); cyc++) begin
            if (cyc > 0) tick();
            if (cyc == 3) a8 = 8'h01;
            if (cyc == 6) a8 = 8'h3C;
            if (done8) begin
                chk($sformatf("b2b_done_at_%0d", k), 64'(cyc), 64'(W + k * (W + 1)));
                chk($sformatf("b2b_sum_%0d", k), 64'({cout8, sum8}), 64'h04B);
                k++;
            end
        end
        chk("b2b_count", 64'(k), 64'd3);
        start8 = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < W + 4 && !seen; i++) begin
            tick();
            if (done8) seen = 1'b1;
        end
        chk("b2b_drain", 64'(seen), 64'd1);
        tick();

        // Asynchronous reset in the 4th RUN cycle.
        run8(8'h5A, 8'hA5, 1'b0, "pre_rst");
        a8 = 8'h77; b8 = 8'h11; cin8 = 1'b0; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        repeat (3) tick();
        chk("mid_busy_before_rst", 64'(busy8), 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("arst_busy", 64'(busy8), 64'd0);
        chk("arst_done", 64'(done8), 64'd0);
        chk("arst_sum", 64'(sum8), 64'd0);
        chk("arst_cout", 64'(cout8), 64'd0);
        #1 rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < W + 2; i++) begin
            tick();
            if (done8 || busy8) seen = 1'b1;
        end
        chk("arst_no_done", 64'(seen), 64'd0);
        run8(8'h10, 8'h20, 1'b0, "after_rst");
        run8(8'hC3, 8'h7E, 1'b1, "hold_30");

        for (int i = 0; i < 16; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rc = 1'($urandom_range(1, 0));
            run8(ra, rb, rc, $sformatf("rnd%0d", i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
